// File: rtl/mem_bus_arbiter_pkg.sv
// mem_bus_arbiter_pkg: shared widths and FSM encoding for the memory bus arbiter
package mem_bus_arbiter_pkg;
    localparam int REG_BUS = 32;
    localparam int INST_ADDR_BUS = 32;
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY_DM = 2'd1,
        BUSY_IF = 2'd2
    } state_e;
endpackage

// File: rtl/mem_bus_arbiter_if.sv
// mem_bus_arbiter_if: unified system-side memory bus, arbiter is master
interface mem_bus_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W/8-1:0] sel;
    logic [DATA_W-1:0] rdata;
    logic              ack;
    modport master (output req, we, addr, wdata, sel, input rdata, ack);
    modport slave (input req, we, addr, wdata, sel, output rdata, ack);
endinterface

// File: rtl/mem_bus_arbiter_bus_wdt.sv
// mem_bus_arbiter_bus_wdt: counts busy cycles without ack, flags the TIMEOUT-th one
module mem_bus_arbiter_bus_wdt #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);
    localparam int W = $clog2(TIMEOUT + 2);
    localparam logic [W-1:0] LAST = W'(TIMEOUT > 0 ? TIMEOUT - 1 : 0);
    logic [W-1:0] cnt_q, cnt_d;
    always_comb cnt_d = clr_i ? '0 : en_i ? cnt_q + 1'b1 : cnt_q;
    always_ff @(posedge clk or posedge rst)
        if (rst) cnt_q <= '0;
        else cnt_q <= cnt_d;
    // TIMEOUT of zero disables the abort entirely
    assign expired_o = (TIMEOUT != 0) && en_i && (cnt_q == LAST);
endmodule

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: single-outstanding fetch/data bus arbiter, data has priority
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter int ADDR_W  = INST_ADDR_BUS,
    parameter int DATA_W  = REG_BUS,
    parameter int TIMEOUT = 255
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                if_req_i,
    input  logic [ADDR_W-1:0]   if_addr_i,
    output logic [DATA_W-1:0]   if_rdata_o,
    output logic                if_ack_o,
    output logic                if_err_o,
    input  logic                dm_req_i,
    input  logic                dm_we_i,
    input  logic [ADDR_W-1:0]   dm_addr_i,
    input  logic [DATA_W-1:0]   dm_wdata_i,
    input  logic [DATA_W/8-1:0] dm_sel_i,
    output logic [DATA_W-1:0]   dm_rdata_o,
    output logic                dm_ack_o,
    output logic                dm_err_o,
    mem_bus_arbiter_if.master   bus,
    output logic                stallreq_from_if_o,
    output logic                stallreq_from_mem_o,
    output logic                bus_err_o
);
    state_e state_q, state_d;
    logic bus_req_q, bus_req_d, bus_we_q, bus_we_d;
    logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
    logic [DATA_W-1:0] bus_wdata_q, bus_wdata_d;
    logic [DATA_W/8-1:0] bus_sel_q, bus_sel_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d, dm_rdata_q, dm_rdata_d;
    logic if_ack_q, if_ack_d, dm_ack_q, dm_ack_d;
    logic if_err_q, if_err_d, dm_err_q, dm_err_d;
    logic bus_err_q, bus_err_d;
    logic busy, expired;

    assign busy = state_q != IDLE;

    mem_bus_arbiter_bus_wdt #(.TIMEOUT(TIMEOUT)) u_bus_wdt (
        .clk      (clk),
        .rst      (rst),
        .clr_i    (!busy),
        .en_i     (busy && !bus.ack),
        .expired_o(expired)
    );

    always_comb begin
        state_d     = state_q;
        bus_req_d   = bus_req_q;
        bus_we_d    = bus_we_q;
        bus_addr_d  = bus_addr_q;
        bus_wdata_d = bus_wdata_q;
        bus_sel_d   = bus_sel_q;
        if_rdata_d  = if_rdata_q;
        dm_rdata_d  = dm_rdata_q;
        if_ack_d    = 1'b0;
        dm_ack_d    = 1'b0;
        if_err_d    = 1'b0;
        dm_err_d    = 1'b0;
        bus_err_d   = bus_err_q;
        if (!busy) begin
            if (dm_req_i || if_req_i) begin
                state_d     = dm_req_i ? BUSY_DM : BUSY_IF;
                bus_req_d   = 1'b1;
                bus_we_d    = dm_req_i ? dm_we_i : 1'b0;
                bus_addr_d  = dm_req_i ? dm_addr_i : if_addr_i;
                bus_wdata_d = dm_req_i ? dm_wdata_i : '0;
                bus_sel_d   = dm_req_i ? dm_sel_i : '1;
            end
        end else if (bus.ack || expired) begin
            // an ack on the expiring cycle still completes cleanly
            state_d   = IDLE;
            bus_req_d = 1'b0;
            bus_err_d = bus_err_q || !bus.ack;
            if (state_q == BUSY_DM) begin
                dm_ack_d   = 1'b1;
                dm_err_d   = !bus.ack;
                dm_rdata_d = !bus.ack ? '0 : bus_we_q ? dm_rdata_q : bus.rdata;
            end else begin
                if_ack_d   = 1'b1;
                if_err_d   = !bus.ack;
                if_rdata_d = bus.ack ? bus.rdata : '0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= '0;
            bus_wdata_q <= '0;
            bus_sel_q   <= '0;
            if_rdata_q  <= '0;
            dm_rdata_q  <= '0;
            if_ack_q    <= 1'b0;
            dm_ack_q    <= 1'b0;
            if_err_q    <= 1'b0;
            dm_err_q    <= 1'b0;
            bus_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            bus_req_q   <= bus_req_d;
            bus_we_q    <= bus_we_d;
            bus_addr_q  <= bus_addr_d;
            bus_wdata_q <= bus_wdata_d;
            bus_sel_q   <= bus_sel_d;
            if_rdata_q  <= if_rdata_d;
            dm_rdata_q  <= dm_rdata_d;
            if_ack_q    <= if_ack_d;
            dm_ack_q    <= dm_ack_d;
            if_err_q    <= if_err_d;
            dm_err_q    <= dm_err_d;
            bus_err_q   <= bus_err_d;
        end
    end

    assign bus.req             = bus_req_q;
    assign bus.we              = bus_we_q;
    assign bus.addr            = bus_addr_q;
    assign bus.wdata           = bus_wdata_q;
    assign bus.sel             = bus_sel_q;
    assign if_rdata_o          = if_rdata_q;
    assign dm_rdata_o          = dm_rdata_q;
    assign if_ack_o            = if_ack_q;
    assign dm_ack_o            = dm_ack_q;
    assign if_err_o            = if_err_q;
    assign dm_err_o            = dm_err_q;
    assign bus_err_o           = bus_err_q;
    assign stallreq_from_if_o  = if_req_i & ~if_ack_q;
    assign stallreq_from_mem_o = dm_req_i & ~dm_ack_q;
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter: directed pins plus randomized traffic against a transaction-level model
module tb_mem_bus_arbiter;
    localparam int TMO = 4;
    logic clk = 1'b0, rst = 1'b1;
    logic if_req_i = 1'b0, dm_req_i = 1'b0, dm_we_i = 1'b0;
    logic [31:0] if_addr_i = '0, dm_addr_i = '0, dm_wdata_i = '0;
    logic [3:0] dm_sel_i = '0;
    logic [31:0] if_rdata_o, dm_rdata_o;
    logic if_ack_o, if_err_o, dm_ack_o, dm_err_o;
    logic stallreq_from_if_o, stallreq_from_mem_o, bus_err_o;
    int passed = 0, total = 0;
    bit rand_en = 0, fixed_mode = 1, spurious = 0;
    int fixed_delay = 0;
    logic [31:0] fixed_rdata = '0;

    mem_bus_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    mem_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst),
        .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_rdata_o(if_rdata_o),
        .if_ack_o(if_ack_o), .if_err_o(if_err_o),
        .dm_req_i(dm_req_i), .dm_we_i(dm_we_i), .dm_addr_i(dm_addr_i),
        .dm_wdata_i(dm_wdata_i), .dm_sel_i(dm_sel_i), .dm_rdata_o(dm_rdata_o),
        .dm_ack_o(dm_ack_o), .dm_err_o(dm_err_o),
        .bus(bus),
        .stallreq_from_if_o(stallreq_from_if_o), .stallreq_from_mem_o(stallreq_from_mem_o),
        .bus_err_o(bus_err_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // memory slave: acks after a chosen number of busy cycles, may never ack
    initial begin
        int s_cnt = 0, s_dly = 0;
        bus.ack = 1'b0;
        bus.rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            if (!bus.req) begin
                s_cnt = 0;
                bus.ack = spurious && ($urandom % 8 == 0);
            end else begin
                if (s_cnt == 0)
                    s_dly = fixed_mode ? fixed_delay : ($urandom % 5 == 0) ? 100 : int'($urandom_range(0, 4));
                bus.ack = (s_cnt == s_dly);
                s_cnt++;
            end
            bus.rdata = fixed_mode ? fixed_rdata : $urandom;
        end
    end

    // random masters: hold a request until acked, occasionally drop it on a stall
    initial forever begin
        @(posedge clk);
        #1;
        if (rand_en) begin
            if (dm_ack_o || !dm_req_i) begin
                dm_req_i = $urandom % 2 == 0;
                dm_we_i = 1'($urandom);
                dm_addr_i = $urandom;
                dm_wdata_i = $urandom;
                dm_sel_i = 4'($urandom);
            end else if ($urandom % 16 == 0) dm_req_i = 1'b0;
            if (if_ack_o || !if_req_i) begin
                if_req_i = $urandom % 3 != 0;
                if_addr_i = $urandom;
            end else if ($urandom % 16 == 0) if_req_i = 1'b0;
        end
    end

    // transaction-level reference: owner 0 = none, 1 = data, 2 = fetch
    int m_own = 0, m_wait = 0;
    logic m_we = 0, m_if_ack = 0, m_dm_ack = 0, m_if_err = 0, m_dm_err = 0, m_berr = 0;
    logic [31:0] m_addr = 0, m_wdata = 0, m_if_rd = 0, m_dm_rd = 0;
    logic [3:0] m_sel = 0;

    initial forever begin
        @(negedge clk);
        if (rst) begin
            m_own = 0; m_wait = 0; m_we = 0; m_addr = 0; m_wdata = 0; m_sel = 0;
            m_if_ack = 0; m_dm_ack = 0; m_if_err = 0; m_dm_err = 0; m_berr = 0;
            m_if_rd = 0; m_dm_rd = 0;
        end
        check("bus_req", bus.req, m_own != 0);
        if (m_own != 0) begin
            check("bus_we", bus.we, m_we);
            check("bus_addr", bus.addr, m_addr);
            check("bus_sel", bus.sel, m_sel);
            if (m_own == 1) check("bus_wdata", bus.wdata, m_wdata);
        end
        check("if_ack", if_ack_o, m_if_ack);
        check("if_err", if_err_o, m_if_err);
        check("if_rdata", if_rdata_o, m_if_rd);
        check("dm_ack", dm_ack_o, m_dm_ack);
        check("dm_err", dm_err_o, m_dm_err);
        check("dm_rdata", dm_rdata_o, m_dm_rd);
        check("bus_err", bus_err_o, m_berr);
        check("stall_if", stallreq_from_if_o, if_req_i & ~m_if_ack);
        check("stall_mem", stallreq_from_mem_o, dm_req_i & ~m_dm_ack);
        if (!rst) begin
            m_if_ack = 0; m_dm_ack = 0; m_if_err = 0; m_dm_err = 0;
            if (m_own == 0) begin
                m_wait = 0;
                if (dm_req_i) begin
                    m_own = 1; m_we = dm_we_i; m_addr = dm_addr_i; m_wdata = dm_wdata_i; m_sel = dm_sel_i;
                end else if (if_req_i) begin
                    m_own = 2; m_we = 0; m_addr = if_addr_i; m_sel = 4'hF;
                end
            end else if (bus.ack) begin
                if (m_own == 1) begin
                    m_dm_ack = 1;
                    if (!m_we) m_dm_rd = bus.rdata;
                end else begin
                    m_if_ack = 1;
                    m_if_rd = bus.rdata;
                end
                m_own = 0;
            end else begin
                m_wait++;
                if (m_wait == TMO) begin
                    if (m_own == 1) begin m_dm_ack = 1; m_dm_err = 1; m_dm_rd = 0; end
                    else begin m_if_ack = 1; m_if_err = 1; m_if_rd = 0; end
                    m_berr = 1;
                    m_own = 0;
                end
            end
        end
    end

    initial begin
        cyc(2);
        check("reset_flags", {bus.req, if_ack_o, dm_ack_o, if_err_o, dm_err_o, bus_err_o}, 0);
        check("reset_rdata", {if_rdata_o, dm_rdata_o}, 0);
        rst = 1'b0;
        // fetch with zero-wait slave
        fixed_rdata = 32'h0000_0013; fixed_delay = 0;
        if_addr_i = 32'h40; if_req_i = 1'b1;
        cyc(1);
        check("fetch_cmd", {bus.req, bus.we, bus.sel, bus.addr}, {1'b1, 1'b0, 4'hF, 32'h40});
        cyc(1);
        check("fetch_ack", if_ack_o, 1);
        check("fetch_rdata", if_rdata_o, 32'h13);
        check("fetch_stall_drop", stallreq_from_if_o, 0);
        // contention: data write goes first, fetch after one bubble
        fixed_rdata = 32'h55;
        dm_req_i = 1'b1; dm_we_i = 1'b1; dm_addr_i = 32'h100; dm_wdata_i = 32'hDEAD_BEEF; dm_sel_i = 4'hF;
        if_addr_i = 32'h44;
        cyc(1);
        check("dm_first", {bus.we, bus.addr}, {1'b1, 32'h100});
        check("dm_wdata", bus.wdata, 32'hDEAD_BEEF);
        cyc(1);
        check("dm_write_ack", dm_ack_o, 1);
        check("write_keeps_if_rdata", if_rdata_o, 32'h13);
        check("write_keeps_dm_rdata", dm_rdata_o, 0);
        check("bubble", bus.req, 0);
        dm_req_i = 1'b0;
        cyc(1);
        check("if_second", {bus.req, bus.we, bus.addr}, {1'b1, 1'b0, 32'h44});
        cyc(1);
        check("if_second_data", {if_ack_o, if_rdata_o}, {1'b1, 32'h55});
        if_req_i = 1'b0;
        // ack on the TIMEOUT-th busy cycle wins over the abort
        fixed_rdata = 32'hA5A5_A5A5; fixed_delay = 3;
        dm_req_i = 1'b1; dm_we_i = 1'b0; dm_addr_i = 32'h200;
        cyc(5);
        check("late_ack", {dm_ack_o, dm_err_o, bus_err_o}, 3'b100);
        check("late_rdata", dm_rdata_o, 32'hA5A5_A5A5);
        // request still high after ack is a new one, and this one is never acked
        fixed_delay = 100; dm_addr_i = 32'h204;
        cyc(4);
        check("held_before_abort", {bus.req, dm_ack_o}, 2'b10);
        cyc(1);
        check("abort", {dm_ack_o, dm_err_o, bus_err_o}, 3'b111);
        check("abort_rdata", dm_rdata_o, 0);
        dm_req_i = 1'b0;
        cyc(1);
        check("bus_err_sticky", {bus_err_o, dm_ack_o}, 2'b10);
        // asynchronous reset in the middle of a fetch
        if_addr_i = 32'h80; if_req_i = 1'b1;
        cyc(2);
        #2 rst = 1'b1;
        #1;
        check("async_reset_flags", {bus.req, if_ack_o, bus_err_o}, 0);
        check("async_reset_rdata", if_rdata_o, 0);
        fixed_delay = 1; fixed_rdata = 32'h77;
        @(posedge clk);
        #2 rst = 1'b0;
        cyc(3);
        check("after_reset_fetch", {if_ack_o, if_rdata_o}, {1'b1, 32'h77});
        if_req_i = 1'b0;
        // randomized traffic
        fixed_mode = 0; spurious = 1; rand_en = 1;
        repeat (3000) @(posedge clk);
        rand_en = 0;
        cyc(1);
        dm_req_i = 1'b0; if_req_i = 1'b0;
        cyc(TMO + 4);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
